// File: rtl/control_word_executor.sv
// Control-word executor: accepts one 55-bit ALU control word per transaction and sequences
// register-file reads, the ALU, memory/stack access, register writeback and the PC increment.
module control_word_executor (
  input  logic        clk,
  input  logic        reset,
  input  logic        cw_valid,
  output logic        cw_ready,
  input  logic [54:0] control_word,
  output logic [3:0]  rf_a_addr,
  output logic [3:0]  rf_b_addr,
  input  logic [15:0] rf_a_data,
  input  logic [15:0] rf_b_data,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_stack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        pc_inc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_STDATA,
    S_MEM,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [54:0] r_word;
  logic [15:0] r_result;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;

  logic        w_pc_inc;
  logic [3:0]  w_alu_op;
  logic [15:0] w_a_altern;
  logic [15:0] w_b_altern;
  logic [3:0]  w_a_select;
  logic [3:0]  w_b_select;
  logic        w_a_source;
  logic        w_b_source;
  logic [3:0]  w_out_select;
  logic [1:0]  w_load_src;
  logic        w_store_mem;
  logic        w_store_stk;
  logic        w_store;
  logic        w_load;

  assign w_pc_inc     = r_word[54];
  assign w_alu_op     = r_word[53:50];
  assign w_a_altern   = r_word[49:34];
  assign w_b_altern   = r_word[33:18];
  assign w_a_select   = r_word[17:14];
  assign w_b_select   = r_word[13:10];
  assign w_a_source   = r_word[9];
  assign w_b_source   = r_word[8];
  assign w_out_select = r_word[7:4];
  assign w_load_src   = r_word[3:2];
  assign w_store_mem  = r_word[1];
  assign w_store_stk  = r_word[0];

  // A store of either kind overrides load_src entirely.
  assign w_store = w_store_mem | w_store_stk;
  assign w_load  = ~w_store & w_load_src[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath registers carry no reset: every output that exposes them is gated by state.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && cw_valid) begin
      r_word <= control_word;
    end
    if (r_state == S_EXEC) begin
      r_result <= alu_result;
    end
    if (r_state == S_STDATA) begin
      r_wdata <= rf_a_data;
    end
    if (r_state == S_MEM && mem_ack) begin
      r_rdata <= mem_rdata;
    end
  end

  always_comb begin
    w_next    = r_state;
    cw_ready  = 1'b0;
    rf_a_addr = 4'd0;
    rf_b_addr = 4'd0;
    alu_op    = 4'd0;
    alu_a     = 16'd0;
    alu_b     = 16'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_stack = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;
    rf_we     = 1'b0;
    rf_waddr  = 4'd0;
    rf_wdata  = 16'd0;
    pc_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cw_ready = 1'b1;
        if (cw_valid) begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        rf_a_addr = w_a_select;
        rf_b_addr = w_b_select;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        alu_op    = w_alu_op;
        alu_a     = w_a_source ? w_a_altern : rf_a_data;
        alu_b     = w_b_source ? w_b_altern : rf_b_data;
        // Port A is reused here to fetch the store data for the next cycle.
        rf_a_addr = w_store ? w_out_select : w_a_select;
        rf_b_addr = w_b_select;
        if (w_store) begin
          w_next = S_STDATA;
        end else if (w_load) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_STDATA: begin
        rf_a_addr = w_out_select;
        w_next    = S_MEM;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = w_store;
        mem_stack = w_store ? (w_store_stk & ~w_store_mem) : w_load_src[0];
        mem_addr  = r_result;
        mem_wdata = w_store ? r_wdata : 16'd0;
        if (mem_ack) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        rf_we    = ~w_store & (w_load_src != 2'b00);
        rf_waddr = w_out_select;
        rf_wdata = w_load_src[1] ? r_rdata : r_result;
        pc_inc   = w_pc_inc;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign busy = ~cw_ready;

endmodule

// File: tb/tb_control_word_executor.sv
// Bench for control_word_executor: register file, ALU and memory are modelled here; directed
// scenarios plus randomized words are checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_control_word_executor;

  logic        clk;
  logic        reset;
  logic        cw_valid;
  logic        cw_ready;
  logic [54:0] control_word;
  logic [3:0]  rf_a_addr, rf_b_addr;
  logic [15:0] rf_a_data, rf_b_data;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        mem_req, mem_we, mem_stack, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        pc_inc, busy;

  control_word_executor dut (
    .clk(clk), .reset(reset), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .control_word(control_word), .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we),
    .mem_stack(mem_stack), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_inc(pc_inc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: register file, ALU, memory ----------------
  logic [15:0] rf [16];
  int          wait_cfg = 0;
  logic [15:0] rdata_cfg = 16'd0;
  logic        late_ack = 1'b0;
  int          mcnt = 0;

  always @(posedge clk) begin
    rf_a_data <= rf[rf_a_addr];
    rf_b_data <= rf[rf_b_addr];
    mcnt      <= mem_req ? mcnt + 1 : 0;
  end

  function automatic logic [15:0] tb_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;   // iadd
      4'd1:    return a;       // left
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return b;
    endcase
  endfunction

  assign alu_result = tb_alu(alu_op, alu_a, alu_b);
  assign mem_ack    = (mem_req && (mcnt == wait_cfg)) || late_ack;
  assign mem_rdata  = rdata_cfg;

  // ---------------- monitor ----------------
  typedef struct { int cyc; logic [3:0] addr; logic [15:0] data; } rfw_t;
  typedef struct { int cyc; int nreq; logic we; logic stk; logic [15:0] addr; logic [15:0] wd; } mac_t;

  rfw_t rf_log[$];
  mac_t mem_log[$];
  int   pc_log[$];
  int   stab_bad = 0;
  int   busy_bad = 0;
  int   mon_n = 0;
  logic [33:0] mon_first;

  always @(negedge clk) begin
    if (rf_we) rf_log.push_back('{cyc, rf_waddr, rf_wdata});
    if (pc_inc) pc_log.push_back(cyc);
    if (busy !== ~cw_ready) busy_bad++;
    if (mem_req) begin
      if (mon_n == 0) mon_first = {mem_we, mem_stack, mem_addr, mem_wdata};
      else if ({mem_we, mem_stack, mem_addr, mem_wdata} !== mon_first) stab_bad++;
      mon_n++;
      if (mem_ack) begin
        mem_log.push_back('{cyc, mon_n, mem_we, mem_stack, mem_addr, mem_wdata});
        mon_n = 0;
      end
    end else begin
      mon_n = 0;
    end
  end

  // ---------------- transaction driver (collects observations only) ----------------
  int   obs_hs, obs_done, obs_nrf, obs_npc, obs_nmem, obs_pc;
  logic obs_hs_ok, obs_timeout;
  rfw_t obs_rf;
  mac_t obs_mem;

  function automatic logic [54:0] mk(input logic pc, input logic [3:0] op, input logic [15:0] aa,
                                     input logic [15:0] ba, input logic [3:0] as, input logic [3:0] bs,
                                     input logic asrc, input logic bsrc, input logic [3:0] os,
                                     input logic [1:0] ls, input logic sm, input logic ss);
    return {pc, op, aa, ba, as, bs, asrc, bsrc, os, ls, sm, ss};
  endfunction

  task automatic run_word(input logic [54:0] w, input int waits);
    int r0, p0, m0;
    @(posedge clk); #1;
    r0 = rf_log.size(); p0 = pc_log.size(); m0 = mem_log.size();
    wait_cfg = waits; control_word = w; cw_valid = 1'b1;
    @(negedge clk);
    obs_hs_ok = cw_ready; obs_hs = cyc;
    @(posedge clk); #1;
    cw_valid = 1'b0;
    control_word = {23'($urandom), $urandom};
    obs_timeout = 1'b1;
    obs_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cw_ready) begin obs_timeout = 1'b0; obs_done = cyc; break; end
    end
    obs_nrf  = rf_log.size() - r0;
    obs_npc  = pc_log.size() - p0;
    obs_nmem = mem_log.size() - m0;
    if (obs_nrf > 0) obs_rf = rf_log[r0];
    if (obs_npc > 0) obs_pc = pc_log[p0];
    if (obs_nmem > 0) obs_mem = mem_log[m0];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; cw_valid = 1'b0; control_word = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cw_ready !== 1'b1) begin n_fail++; $display("FAIL reset.cw_ready got=%0b exp=1", cw_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got=%0b exp=0", busy); end
    n_cmp++; if ({mem_req, mem_we, mem_stack, rf_we, pc_inc} !== 5'b0) begin n_fail++;
      $display("FAIL reset.strobes got=%b exp=00000", {mem_req, mem_we, mem_stack, rf_we, pc_inc}); end
    n_cmp++; if ({rf_a_addr, rf_b_addr, rf_waddr, alu_op} !== 16'h0) begin n_fail++;
      $display("FAIL reset.addrs got=%h exp=0", {rf_a_addr, rf_b_addr, rf_waddr, alu_op}); end
    n_cmp++; if ({alu_a, alu_b, mem_addr, mem_wdata, rf_wdata} !== 80'h0) begin n_fail++;
      $display("FAIL reset.data got=%h exp=0", {alu_a, alu_b, mem_addr, mem_wdata, rf_wdata}); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (cw_ready !== 1'b1) begin n_fail++; $display("FAIL reset.idle_after got=%0b exp=1", cw_ready); end
  endtask

  task automatic test_alu_wb();
    rf[1] = 16'h0003; rf[2] = 16'h0004;
    run_word(mk(1'b1, 4'd0, 16'h1111, 16'h2222, 4'd1, 4'd2, 1'b0, 1'b0, 4'd5, 2'b01, 1'b0, 1'b0), 0);
    n_cmp++; if (obs_hs_ok !== 1'b1 || obs_timeout !== 1'b0) begin n_fail++;
      $display("FAIL alu_wb.handshake got=%0b/%0b exp=1/0", obs_hs_ok, obs_timeout); end
    n_cmp++; if (obs_done - obs_hs !== 4) begin n_fail++; $display("FAIL alu_wb.ready_T got=%0d exp=4", obs_done - obs_hs); end
    n_cmp++; if (obs_nrf !== 1) begin n_fail++; $display("FAIL alu_wb.n_rf_we got=%0d exp=1", obs_nrf); end
    n_cmp++; if (obs_rf.addr !== 4'd5 || obs_rf.data !== 16'h0007) begin n_fail++;
      $display("FAIL alu_wb.write got=R%0d<-%h exp=R5<-0007", obs_rf.addr, obs_rf.data); end
    n_cmp++; if (obs_rf.cyc - obs_hs !== 3) begin n_fail++; $display("FAIL alu_wb.wb_T got=%0d exp=3", obs_rf.cyc - obs_hs); end
    n_cmp++; if (obs_npc !== 1 || obs_pc - obs_hs !== 3) begin n_fail++;
      $display("FAIL alu_wb.pc_inc got=n%0d@T%0d exp=n1@T3", obs_npc, obs_pc - obs_hs); end
    n_cmp++; if (obs_nmem !== 0) begin n_fail++; $display("FAIL alu_wb.no_mem got=%0d exp=0", obs_nmem); end
  endtask

  task automatic test_switch_load();
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
    run_word(mk(1'b0, 4'd1, 16'hBEEF, 16'($urandom), 4'd3, 4'd4, 1'b1, 1'b0, 4'd3, 2'b01, 1'b0, 1'b0), 0);
    n_cmp++; if (obs_nrf !== 1 || obs_rf.addr !== 4'd3 || obs_rf.data !== 16'hBEEF) begin n_fail++;
      $display("FAIL switch.write got=n%0d R%0d<-%h exp=n1 R3<-beef", obs_nrf, obs_rf.addr, obs_rf.data); end
    n_cmp++; if (obs_npc !== 0) begin n_fail++; $display("FAIL switch.pc_inc got=%0d exp=0", obs_npc); end
  endtask

  task automatic test_mem_load_wait();
    int sb;
    sb = stab_bad;
    rf[4] = 16'h0100; rdata_cfg = 16'h1234;
    run_word(mk(1'b0, 4'd1, 16'h0, 16'h0, 4'd4, 4'd0, 1'b0, 1'b0, 4'd6, 2'b10, 1'b0, 1'b0), 3);
    n_cmp++; if (obs_nmem !== 1) begin n_fail++; $display("FAIL load.n_mem got=%0d exp=1", obs_nmem); end
    n_cmp++; if (obs_mem.nreq !== 4) begin n_fail++; $display("FAIL load.req_cycles got=%0d exp=4", obs_mem.nreq); end
    n_cmp++; if (obs_mem.addr !== 16'h0100 || obs_mem.we !== 1'b0 || obs_mem.stk !== 1'b0) begin n_fail++;
      $display("FAIL load.req got=a%h we%0b s%0b exp=a0100 we0 s0", obs_mem.addr, obs_mem.we, obs_mem.stk); end
    n_cmp++; if (obs_mem.cyc - obs_hs !== 6) begin n_fail++; $display("FAIL load.ack_T got=%0d exp=6", obs_mem.cyc - obs_hs); end
    n_cmp++; if (stab_bad !== sb) begin n_fail++; $display("FAIL load.stable got=%0d exp=%0d", stab_bad, sb); end
    n_cmp++; if (obs_nrf !== 1 || obs_rf.addr !== 4'd6 || obs_rf.data !== 16'h1234) begin n_fail++;
      $display("FAIL load.write got=n%0d R%0d<-%h exp=n1 R6<-1234", obs_nrf, obs_rf.addr, obs_rf.data); end
    n_cmp++; if (obs_rf.cyc !== obs_mem.cyc + 1) begin n_fail++;
      $display("FAIL load.wb_after_ack got=%0d exp=%0d", obs_rf.cyc, obs_mem.cyc + 1); end
    n_cmp++; if (obs_done - obs_hs !== 8) begin n_fail++; $display("FAIL load.ready_T got=%0d exp=8", obs_done - obs_hs); end
  endtask

  task automatic test_stack_store();
    rf[7] = 16'h0010; rf[2] = 16'h0002; rf[9] = 16'hCAFE;
    run_word(mk(1'b1, 4'd0, 16'h0, 16'h0, 4'd7, 4'd2, 1'b0, 1'b0, 4'd9, 2'b10, 1'b0, 1'b1), 0);
    n_cmp++; if (obs_nmem !== 1 || obs_mem.we !== 1'b1 || obs_mem.stk !== 1'b1) begin n_fail++;
      $display("FAIL store.req got=n%0d we%0b s%0b exp=n1 we1 s1", obs_nmem, obs_mem.we, obs_mem.stk); end
    n_cmp++; if (obs_mem.addr !== 16'h0012 || obs_mem.wd !== 16'hCAFE) begin n_fail++;
      $display("FAIL store.addr_data got=%h/%h exp=0012/cafe", obs_mem.addr, obs_mem.wd); end
    n_cmp++; if (obs_nrf !== 0) begin n_fail++; $display("FAIL store.rf_we got=%0d exp=0", obs_nrf); end
    n_cmp++; if (obs_done - obs_hs !== 6 || obs_mem.cyc - obs_hs !== 4) begin n_fail++;
      $display("FAIL store.timing got=ack%0d/rdy%0d exp=4/6", obs_mem.cyc - obs_hs, obs_done - obs_hs); end
    run_word(mk(1'b0, 4'd0, 16'h0, 16'h0, 4'd7, 4'd2, 1'b0, 1'b0, 4'd9, 2'b01, 1'b1, 1'b1), 1);
    n_cmp++; if (obs_nmem !== 1 || obs_mem.we !== 1'b1 || obs_mem.stk !== 1'b0 || obs_nrf !== 0) begin n_fail++;
      $display("FAIL both_store got=n%0d we%0b s%0b rf%0d exp=n1 we1 s0 rf0", obs_nmem, obs_mem.we, obs_mem.stk, obs_nrf); end
  endtask

  task automatic test_back_to_back();
    int p0, c0, hs_n, rd_bad;
    p0 = pc_log.size();
    @(posedge clk); #1;
    control_word = mk(1'b1, 4'd0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    cw_valid = 1'b1;
    @(negedge clk);
    c0 = cyc; hs_n = 0; rd_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (cw_ready) hs_n++;
      if (cw_ready !== (((cyc - c0) % 4) == 0)) rd_bad++;
    end
    @(posedge clk); #1; cw_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (hs_n !== 3) begin n_fail++; $display("FAIL b2b.handshakes got=%0d exp=3", hs_n); end
    n_cmp++; if (rd_bad !== 0) begin n_fail++; $display("FAIL b2b.ready_pattern got=%0d bad exp=0", rd_bad); end
    n_cmp++; if (pc_log.size() - p0 !== 3) begin n_fail++; $display("FAIL b2b.n_pc got=%0d exp=3", pc_log.size() - p0); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (pc_log[p0 + k] !== c0 + 3 + 4 * k) begin n_fail++;
        $display("FAIL b2b.pc_T got=%0d exp=%0d", pc_log[p0 + k] - c0, 3 + 4 * k); end
    end
  endtask

  task automatic test_reset_mid_mem();
    int r0;
    logic got;
    rf[4] = 16'h0200;
    r0 = rf_log.size();
    @(posedge clk); #1;
    wait_cfg = 50;
    control_word = mk(1'b1, 4'd1, 16'h0, 16'h0, 4'd4, 4'd0, 1'b0, 1'b0, 4'd6, 2'b10, 1'b0, 1'b0);
    cw_valid = 1'b1;
    @(posedge clk); #1; cw_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin got = 1'b1; break; end
    end
    n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rst_mem.reached_mem got=%0b exp=1", got); end
    @(posedge clk); #1;
    reset = 1'b1; #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem.mem_req got=%0b exp=0", mem_req); end
    n_cmp++; if (cw_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_mem.idle got=rdy%0b busy%0b exp=rdy1 busy0", cw_ready, busy); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; late_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_req, rf_we, cw_ready} !== 3'b001) begin n_fail++;
      $display("FAIL rst_mem.late_ack got=%b exp=001", {mem_req, rf_we, cw_ready}); end
    @(posedge clk); #1; late_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (rf_log.size() !== r0 || cw_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_mem.no_write got=%0d/%0b exp=%0d/1", rf_log.size(), cw_ready, r0); end
    rdata_cfg = 16'h5A5A;
    run_word(mk(1'b0, 4'd1, 16'h0, 16'h0, 4'd4, 4'd0, 1'b0, 1'b0, 4'd6, 2'b10, 1'b0, 1'b0), 0);
    n_cmp++; if (obs_nrf !== 1 || obs_rf.data !== 16'h5A5A || obs_mem.addr !== 16'h0200) begin n_fail++;
      $display("FAIL rst_mem.recover got=n%0d %h @%h exp=n1 5a5a @0200", obs_nrf, obs_rf.data, obs_mem.addr); end
  endtask

  task automatic test_random();
    logic [54:0] w;
    logic [15:0] a, b, res;
    logic        store, exp_rf, exp_mem, exp_stk;
    logic [15:0] exp_rf_data;
    int          waits, lat;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
      w = {23'($urandom), $urandom};
      waits = $urandom_range(0, 3);
      rdata_cfg = 16'($urandom);
      // Transaction-level expectation from the word's fields.
      a = w[9] ? w[49:34] : rf[w[17:14]];
      b = w[8] ? w[33:18] : rf[w[13:10]];
      res = tb_alu(w[53:50], a, b);
      store = w[1] | w[0];
      exp_mem = store | w[3];
      exp_stk = store ? (w[0] & ~w[1]) : w[2];
      exp_rf = !store && (w[3:2] != 2'b00);
      exp_rf_data = w[3] ? rdata_cfg : res;
      lat = store ? 6 + waits : (w[3] ? 5 + waits : 4);
      run_word(w, waits);
      n_cmp++; if (obs_timeout !== 1'b0 || obs_done - obs_hs !== lat) begin n_fail++;
        $display("FAIL rand[%0d].latency got=%0d exp=%0d", it, obs_done - obs_hs, lat); end
      n_cmp++; if (obs_npc !== int'(w[54])) begin n_fail++; $display("FAIL rand[%0d].n_pc got=%0d exp=%0d", it, obs_npc, w[54]); end
      n_cmp++; if (obs_nrf !== int'(exp_rf)) begin n_fail++; $display("FAIL rand[%0d].n_rf got=%0d exp=%0d", it, obs_nrf, exp_rf); end
      if (exp_rf) begin
        n_cmp++; if (obs_rf.addr !== w[7:4] || obs_rf.data !== exp_rf_data || obs_rf.cyc !== obs_hs + lat - 1) begin n_fail++;
          $display("FAIL rand[%0d].rf got=R%0d<-%h@%0d exp=R%0d<-%h@%0d", it, obs_rf.addr, obs_rf.data,
                   obs_rf.cyc - obs_hs, w[7:4], exp_rf_data, lat - 1); end
      end
      n_cmp++; if (obs_nmem !== int'(exp_mem)) begin n_fail++; $display("FAIL rand[%0d].n_mem got=%0d exp=%0d", it, obs_nmem, exp_mem); end
      if (exp_mem) begin
        n_cmp++; if (obs_mem.we !== store || obs_mem.stk !== exp_stk || obs_mem.addr !== res || obs_mem.nreq !== waits + 1) begin
          n_fail++; $display("FAIL rand[%0d].mem got=we%0b s%0b a%h n%0d exp=we%0b s%0b a%h n%0d", it, obs_mem.we,
                             obs_mem.stk, obs_mem.addr, obs_mem.nreq, store, exp_stk, res, waits + 1); end
        if (store) begin
          n_cmp++; if (obs_mem.wd !== rf[w[7:4]]) begin n_fail++;
            $display("FAIL rand[%0d].wdata got=%h exp=%h", it, obs_mem.wd, rf[w[7:4]]); end
        end
      end
    end
    n_cmp++; if (stab_bad !== 0) begin n_fail++; $display("FAIL mem_stable got=%0d exp=0", stab_bad); end
    n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("FAIL busy_vs_ready got=%0d exp=0", busy_bad); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'd0;
    test_reset();
    test_alu_wb();
    test_switch_load();
    test_mem_load_wait();
    test_stack_store();
    test_back_to_back();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
